// File: rtl/keypad_scan_pkg.sv
// -----------------------------------------------------------------------------
// keypad_scan_pkg
//   Shared definitions for the scanned 4x4 keypad reader.
//   Contents:
//     KEY_W      width of a key code {row_idx[1:0], col_idx[1:0]}
//     ROW_PAT    active-low one-hot row drive pattern indexed by row_idx
//     state_t    debounce FSM states (IDLE, DEBOUNCE, PRESSED)
//     frame_cls_t / frame_info_t  result of classifying one 16-bit frame image
//     classify() counts closed contacts in a frame image and returns the code
//                of the closed contact when there is exactly one
// -----------------------------------------------------------------------------
package keypad_scan_pkg;

   localparam int KEY_W = 4;

   localparam logic [3:0] ROW_PAT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CLS_NONE   = 2'd0,
      CLS_SINGLE = 2'd1,
      CLS_MULTI  = 2'd2
   } frame_cls_t;

   typedef struct packed {
      frame_cls_t       cls;
      logic [KEY_W-1:0] code;
   } frame_info_t;

   // Image bit r*4+c is the active-low contact at row index r, column index c,
   // so the bit position of a lone zero is directly the key code.
   function automatic frame_info_t classify(input logic [15:0] img);
      frame_info_t info;
      int unsigned zeros;
      zeros     = 0;
      info.code = '0;
      for (int i = 0; i < 16; i++) begin
         if (!img[i]) begin
            zeros++;
            info.code = KEY_W'(i);
         end
      end
      if (zeros == 0)      info.cls = CLS_NONE;
      else if (zeros == 1) info.cls = CLS_SINGLE;
      else                 info.cls = CLS_MULTI;
      return info;
   endfunction

endpackage

// File: rtl/keypad_scan_cnt_mod4.sv
// -----------------------------------------------------------------------------
// cnt_mod4
//   Two-bit wrapping counter advanced only when ena is high.
//   Ports:
//     clk    in   system clock
//     rst_n  in   synchronous active-low reset (q <= 0)
//     ena    in   advance enable
//     q      out  current count 0..3
// -----------------------------------------------------------------------------
module cnt_mod4 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   output logic [1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst_n)   q <= 2'd0;
      else if (ena) q <= q + 2'd1;
   end

endmodule

// File: rtl/keypad_scan_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//   Free-running prescaler counting 0..DIV-1; tick is high for the single clk
//   in which the count equals DIV-1, after which the count wraps to 0.
//   Ports:
//     clk    in   system clock
//     rst_n  in   synchronous active-low reset (count <= 0)
//     tick   out  one-clk strobe every DIV clks
// -----------------------------------------------------------------------------
module tick_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   assign tick = (count == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n)    count <= '0;
      else if (tick) count <= '0;
      else           count <= count + CW'(1);
   end

endmodule

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
//   Scanned 4x4 matrix keypad reader. Drives one row low at a time, samples
//   the pulled-up active-low columns, builds a 16-bit image per scan frame and
//   debounces over whole frames, reporting one key code per accepted press.
//   Ports:
//     clk        in   system clock
//     rst_n      in   synchronous active-low reset
//     col_n      in   [4:1] column lines, 0 = contact on driven row (async)
//     row_n      out  [4:1] row drive, exactly one bit low
//     key        out  [4:1] accepted code {row_idx, col_idx}, held until next press
//     key_valid  out  one-clk pulse when a press is accepted
//     key_held   out  high from key_valid until the release is accepted
// -----------------------------------------------------------------------------
module keypad_scan
   import keypad_scan_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int SCAN_HZ        = 1_000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:1] col_n,
   output logic [4:1] row_n,
   output logic [4:1] key,
   output logic       key_valid,
   output logic       key_held
);

   localparam int DIV   = CLK_HZ / SCAN_HZ;
   localparam int CNT_W = (DEBOUNCE_SCANS > 0) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
   localparam logic [CNT_W-1:0] DS_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

   logic             tick;
   logic [1:0]       row_idx;
   logic [3:0]       col_meta;
   logic [3:0]       col_sync;
   logic [3:0]       img [3];
   logic             frame_end;
   logic [15:0]      frame_img;
   frame_info_t      info;
   state_t           state;
   logic [KEY_W-1:0] cand;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] rel_cnt;

   tick_gen #(.DIV(DIV)) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   cnt_mod4 u_row_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (tick),
      .q     (row_idx)
   );

   assign row_n = ROW_PAT[row_idx];

   // Two-stage synchroniser; reset to "no contact" so a reset never looks like a press.
   // NOTE: every clocked block uses non-blocking assignments so all registers
   // update together from pre-edge values; blocking here would collapse the
   // two synchroniser stages into one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_meta <= 4'b1111;
         col_sync <= 4'b1111;
      end else begin
         col_meta <= col_n;
         col_sync <= col_meta;
      end
   end

   // Only rows 0..2 are stored: row 3 is sampled on the frame-end tick and is
   // classified straight from col_sync in that same cycle.
   // NOTE: the image is explicitly cleared on reset because a stale image could
   // otherwise be classified as a key on the first frame after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         img[0] <= 4'b1111;
         img[1] <= 4'b1111;
         img[2] <= 4'b1111;
      end else if (tick) begin
         case (row_idx)
            2'd0:    img[0] <= col_sync;
            2'd1:    img[1] <= col_sync;
            2'd2:    img[2] <= col_sync;
            default: ;
         endcase
      end
   end

   assign frame_end = tick && (row_idx == 2'd3);
   assign frame_img = {col_sync, img[2], img[1], img[0]};
   assign info      = classify(frame_img);

   // Debounce FSM; acts only at frame end, key_valid otherwise returns low.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cand      <= '0;
         cnt       <= '0;
         rel_cnt   <= '0;
         key       <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (frame_end) begin
            case (state)
               ST_IDLE: begin
                  if (info.cls == CLS_SINGLE) begin
                     if (DEBOUNCE_SCANS == 1) begin
                        state     <= ST_PRESSED;
                        key       <= info.code;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        rel_cnt   <= '0;
                     end else begin
                        state <= ST_DEBOUNCE;
                        cand  <= info.code;
                        cnt   <= CNT_W'(1);
                     end
                  end
               end
               ST_DEBOUNCE: begin
                  if (info.cls == CLS_SINGLE && info.code == cand) begin
                     if (cnt == DS_LAST) begin
                        state     <= ST_PRESSED;
                        key       <= cand;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        rel_cnt   <= '0;
                     end else begin
                        cnt <= cnt + CNT_W'(1);
                     end
                  end else if (info.cls == CLS_SINGLE) begin
                     cand <= info.code;
                     cnt  <= CNT_W'(1);
                  end else begin
                     state <= ST_IDLE;
                     cnt   <= '0;
                  end
               end
               ST_PRESSED: begin
                  // Any contact (same key, new key or ghost pattern) restarts the
                  // release count and never produces a second key_valid.
                  if (info.cls == CLS_NONE) begin
                     if (rel_cnt == DS_LAST) begin
                        state    <= ST_IDLE;
                        key_held <= 1'b0;
                        rel_cnt  <= '0;
                        cnt      <= '0;
                     end else begin
                        rel_cnt <= rel_cnt + CNT_W'(1);
                     end
                  end else begin
                     rel_cnt <= '0;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
